// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode and fetch-state types plus the default PC width
package cpu_pkg;
  localparam int DEF_PC_W = 10;
  typedef enum logic [4:0] {
    OP_LV = 5'd1, OP_ADD = 5'd2, OP_SUB = 5'd3, OP_AND = 5'd4, OP_OR = 5'd5,
    OP_CP = 5'd6, OP_B = 5'd7, OP_BEQ = 5'd8, OP_SLR = 5'd9, OP_GP = 5'd10,
    OP_HALT = 5'd31
  } opcode_e;
  typedef enum logic [2:0] {IDLE, RUN, STALL, REDIRECT, HALT} fetch_state_e;
  function automatic logic is_halt(input logic [31:0] w);
    return w[31:27] == OP_HALT;
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding register for the word that lands while decode is stalled
module fetch_skid import cpu_pkg::*; #(
  parameter int PC_W = DEF_PC_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic            pop,
  input  logic [31:0]     din,
  input  logic [PC_W-1:0] pin,
  output logic [31:0]     data,
  output logic [PC_W-1:0] pc,
  output logic            valid
);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      data <= '0;
      pc <= '0;
      valid <= 1'b0;
    end else if (clear) valid <= 1'b0;
    else if (load) begin
      data <= din;
      pc <= pin;
      valid <= 1'b1;
    end else if (pop) valid <= 1'b0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: one-word-per-cycle instruction fetch with stall skid, branch redirect and HALT
module fetch_unit import cpu_pkg::*; #(
  parameter int              PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            Stall,
  input  logic            BranchTaken,
  input  logic [PC_W-1:0] BranchTarget,
  input  logic [31:0]     ImemData,
  output logic [PC_W-1:0] ImemAddr,
  output logic            ImemRdEn,
  output logic [31:0]     Instruccion,
  output logic [PC_W-1:0] PcOut,
  output logic            InstrValid,
  output logic            Halted
);
  fetch_state_e state, state_n;
  logic [PC_W-1:0] pc, fpc, skid_pc;
  logic [31:0] skid_data;
  logic skid_valid, redirect, take_run, take_skid, skid_load, rd;
  fetch_skid #(.PC_W(PC_W)) u_skid (
    .clock(clock), .reset(reset), .load(skid_load), .clear(redirect), .pop(take_skid),
    .din(ImemData), .pin(fpc), .data(skid_data), .pc(skid_pc), .valid(skid_valid)
  );
  // fpc tracks the address of the word currently arriving on ImemData
  always_comb begin
    redirect = BranchTaken && state != IDLE;
    take_run = state == RUN && !Stall && !redirect;
    take_skid = state == STALL && !Stall && !redirect;
    skid_load = state == RUN && Stall && !redirect;
    rd = (state inside {IDLE, REDIRECT}) ||
         ((state inside {RUN, STALL}) && !Stall && !BranchTaken);
    state_n = state;
    if (redirect) state_n = REDIRECT;
    else if (take_run) state_n = is_halt(ImemData) ? HALT : RUN;
    else if (take_skid) state_n = is_halt(skid_data) ? HALT : RUN;
    else if (skid_load) state_n = STALL;
    else if (state inside {IDLE, REDIRECT}) state_n = RUN;
  end
  assign ImemAddr = pc;
  assign ImemRdEn = rd && !reset;
  assign Halted = state == HALT;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      fpc <= '0;
      Instruccion <= '0;
      PcOut <= '0;
      InstrValid <= 1'b0;
    end else begin
      state <= state_n;
      if (redirect) pc <= BranchTarget;
      else if (rd) begin
        pc <= pc + PC_W'(1);
        fpc <= pc;
      end
      if (redirect || (state == HALT && !Stall)) InstrValid <= 1'b0;
      else if (take_run) begin
        Instruccion <= ImemData;
        PcOut <= fpc;
        InstrValid <= 1'b1;
      end else if (take_skid) begin
        Instruccion <= skid_data;
        PcOut <= skid_pc;
        InstrValid <= skid_valid;
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector tables plus randomized run against a word-stream model
module tb_fetch_unit;
  logic clock = 1'b0;
  logic reset, stall, br, reset1, st1, br1;
  logic [9:0] tgt, tgt1, iaddr, iaddr1, pcout, pcout1;
  logic [31:0] idata, idata1, ins, ins1;
  logic rden, rden1, vld, vld1, hlt, hlt1;
  logic [31:0] mem [1024];
  int total = 0, pass = 0;
  typedef struct {
    logic st; logic br; logic [9:0] tgt;
    logic rd; logic [9:0] addr; logic v; logic [9:0] pc; logic [31:0] ins; logic h;
  } vec_t;
  vec_t tv0 [16];
  vec_t tv1 [9];
  localparam logic [31:0] XW = 32'h3000_0ABC;
  localparam logic [31:0] HW = 32'hF800_0001;

  always #5 clock = ~clock;
  always @(posedge clock) begin
    idata <= mem[iaddr];
    idata1 <= mem[iaddr1];
  end

  fetch_unit u0 (
    .clock(clock), .reset(reset), .Stall(stall), .BranchTaken(br), .BranchTarget(tgt),
    .ImemData(idata), .ImemAddr(iaddr), .ImemRdEn(rden), .Instruccion(ins),
    .PcOut(pcout), .InstrValid(vld), .Halted(hlt)
  );
  fetch_unit #(.RESET_PC(10'd1022)) u1 (
    .clock(clock), .reset(reset1), .Stall(st1), .BranchTaken(br1), .BranchTarget(tgt1),
    .ImemData(idata1), .ImemAddr(iaddr1), .ImemRdEn(rden1), .Instruccion(ins1),
    .PcOut(pcout1), .InstrValid(vld1), .Halted(hlt1)
  );

  function automatic logic [31:0] w(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  function automatic vec_t mk(input int st, input int b, input int t, input int rd,
                              input int addr, input int v, input int pc,
                              input logic [31:0] iw, input int h);
    vec_t r;
    r.st = 1'(st); r.br = 1'(b); r.tgt = 10'(t); r.rd = 1'(rd); r.addr = 10'(addr);
    r.v = 1'(v); r.pc = 10'(pc); r.ins = iw; r.h = 1'(h);
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  // drive one cycle of a vector on u0 (u=0) or u1 (u=1), check, move to next negedge
  task automatic apply(input string tag, input vec_t x, input bit u);
    logic rd_a, v_a, h_a;
    logic [9:0] ad_a, pc_a;
    logic [31:0] in_a;
    if (u) begin st1 = x.st; br1 = x.br; tgt1 = x.tgt; end
    else begin stall = x.st; br = x.br; tgt = x.tgt; end
    #1;
    rd_a = u ? rden1 : rden;   ad_a = u ? iaddr1 : iaddr;
    v_a = u ? vld1 : vld;      pc_a = u ? pcout1 : pcout;
    in_a = u ? ins1 : ins;     h_a = u ? hlt1 : hlt;
    chk({tag, ".rden"}, 32'(rd_a), 32'(x.rd));
    if (x.rd) chk({tag, ".addr"}, 32'(ad_a), 32'(x.addr));
    chk({tag, ".valid"}, 32'(v_a), 32'(x.v));
    chk({tag, ".pcout"}, 32'(pc_a), 32'(x.pc));
    chk({tag, ".instr"}, in_a, x.ins);
    chk({tag, ".halted"}, 32'(h_a), 32'(x.h));
    @(negedge clock);
  endtask

  logic m_idle, m_warm, m_halt, m_v, s, b, e_rd;
  logic [9:0] m_addr, m_pc, t;
  logic [31:0] m_ins;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = w(i);
    reset = 1'b1; reset1 = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;
    st1 = 1'b0; br1 = 1'b0; tgt1 = '0;
    tv0[0]  = mk(0,0,0,     1,0,     0,0,     32'h0,  0);
    tv0[1]  = mk(0,0,0,     1,1,     0,0,     32'h0,  0);
    tv0[2]  = mk(0,0,0,     1,2,     1,0,     w(0),   0);
    tv0[3]  = mk(1,0,0,     0,0,     1,1,     w(1),   0);
    tv0[4]  = mk(1,0,0,     0,0,     1,1,     w(1),   0);
    tv0[5]  = mk(1,0,0,     0,0,     1,1,     w(1),   0);
    tv0[6]  = mk(0,0,0,     1,3,     1,1,     w(1),   0);
    tv0[7]  = mk(0,1,'h40,  0,0,     1,2,     w(2),   0);
    tv0[8]  = mk(0,0,0,     1,'h40,  0,2,     w(2),   0);
    tv0[9]  = mk(0,0,0,     1,'h41,  0,2,     w(2),   0);
    tv0[10] = mk(1,1,'h80,  0,0,     1,'h40,  w('h40),0);
    tv0[11] = mk(0,0,0,     1,'h80,  0,'h40,  w('h40),0);
    tv0[12] = mk(0,0,0,     1,'h81,  0,'h40,  w('h40),0);
    tv0[13] = mk(1,0,0,     0,0,     1,'h80,  w('h80),0);
    tv0[14] = mk(0,0,0,     1,'h82,  1,'h80,  w('h80),0);
    tv0[15] = mk(0,0,0,     1,'h83,  1,'h81,  w('h81),0);
    tv1[0]  = mk(0,0,0,     1,1022,  0,0,     32'h0,  0);
    tv1[1]  = mk(0,0,0,     1,1023,  0,0,     32'h0,  0);
    tv1[2]  = mk(0,0,0,     1,0,     1,1022,  w(1022),0);
    tv1[3]  = mk(0,0,0,     1,1,     1,1023,  XW,     0);
    tv1[4]  = mk(0,0,0,     0,0,     1,0,     HW,     1);
    tv1[5]  = mk(0,1,5,     0,0,     0,0,     HW,     1);
    tv1[6]  = mk(0,0,0,     1,5,     0,0,     HW,     0);
    tv1[7]  = mk(0,0,0,     1,6,     0,0,     HW,     0);
    tv1[8]  = mk(0,0,0,     1,7,     1,5,     w(5),   0);
    repeat (2) @(negedge clock);
    #1;
    chk("rst.rden", 32'(rden), 32'h0);
    chk("rst.valid", 32'(vld), 32'h0);
    chk("rst.instr", ins, 32'h0);
    chk("rst.halted", 32'(hlt), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) apply($sformatf("line[%0d]", k), tv0[k], 1'b0);
    // reset pulse while parked in STALL with a word in the skid
    stall = 1'b1; br = 1'b0;
    #1 chk("mid.rden_stall", 32'(rden), 32'h0);
    @(negedge clock);
    chk("mid.pre_instr", ins, w('h82));
    #2 reset = 1'b1;
    #1;
    chk("mid.instr", ins, 32'h0);
    chk("mid.pcout", 32'(pcout), 32'h0);
    chk("mid.valid", 32'(vld), 32'h0);
    chk("mid.rden", 32'(rden), 32'h0);
    chk("mid.halted", 32'(hlt), 32'h0);
    @(negedge clock);
    reset = 1'b0; stall = 1'b0;
    #1 chk("mid.rden_after", 32'(rden), 32'h1);
    chk("mid.addr_after", 32'(iaddr), 32'h0);
    @(negedge clock);
    #1 chk("mid.addr1", 32'(iaddr), 32'h1);
    @(negedge clock);
    #1 chk("mid.first_instr", ins, w(0));
    chk("mid.first_valid", 32'(vld), 32'h1);
    // wrap through 1023 -> 0 into a HALT word
    mem[1023] = XW;
    mem[0] = HW;
    @(negedge clock);
    reset1 = 1'b0;
    for (int k = 0; k < 9; k++) apply($sformatf("wrap[%0d]", k), tv1[k], 1'b1);
    // randomized run against the word-stream model
    for (int i = 0; i < 1024; i++)
      mem[i] = {($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(1, 10)), 27'($urandom)};
    @(negedge clock);
    reset = 1'b1; stall = 1'b0; br = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    m_idle = 1'b1; m_warm = 1'b1; m_halt = 1'b0; m_v = 1'b0;
    m_addr = '0; m_pc = '0; m_ins = '0;
    for (int c = 0; c < 1500; c++) begin
      s = $urandom_range(0, 9) < 3;
      b = $urandom_range(0, 11) == 0;
      t = 10'($urandom);
      stall = s; br = b; tgt = t;
      #1;
      e_rd = m_halt ? 1'b0 : m_warm ? 1'b1 : (!s && !b);
      chk($sformatf("rnd[%0d].rden", c), 32'(rden), 32'(e_rd));
      if (e_rd) chk($sformatf("rnd[%0d].addr", c), 32'(iaddr), 32'(m_warm ? m_addr : m_addr + 10'd1));
      chk($sformatf("rnd[%0d].valid", c), 32'(vld), 32'(m_v));
      chk($sformatf("rnd[%0d].pcout", c), 32'(pcout), 32'(m_pc));
      chk($sformatf("rnd[%0d].instr", c), ins, m_ins);
      chk($sformatf("rnd[%0d].halted", c), 32'(hlt), 32'(m_halt));
      if (b && !m_idle) begin
        m_v = 1'b0; m_addr = t; m_warm = 1'b1; m_halt = 1'b0;
      end else if (m_warm) begin
        m_warm = 1'b0; m_idle = 1'b0;
      end else if (m_halt) begin
        if (!s) m_v = 1'b0;
      end else if (!s) begin
        m_ins = mem[m_addr]; m_pc = m_addr; m_v = 1'b1; m_addr = m_addr + 10'd1;
        if (m_ins[31:27] == 5'd31) m_halt = 1'b1;
      end
      @(negedge clock);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
